riscv_single_cycle_core: RTL and testbench

Single-cycle RV32I integer core. Each rising clock edge fetches, decodes, executes and retires one instruction. It contains its own instruction memory, data memory and register file. It is the top of the single-cycle processor and has no ports other than clock and reset; benches preload the instruction memory by hierarchical reference and observe internal state.

---
 rtl/riscv_single_cycle_core.sv | 248 ++++++++++++++++++++++++
 tb/tb_riscv_single_cycle_core.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_single_cycle_core.sv
// Single-cycle RV32I core: fetch, decode, execute and retire one instruction
// per rising clock edge. Contains its own instruction memory, data memory and
// register file.

// Word-addressed instruction ROM with a load port, preloaded by benches.
module riscv_imem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_data_i,
  input  logic [31:0]              addr_i,
  output logic [31:0]              rdata_o
);
  localparam int AW = $clog2(DEPTH);

  reg   [31:0] memfile [0:DEPTH-1];
  logic [31:0] word_s;
  logic        unused_s;

  // Byte address to word index, wrapping around the memory depth.
  assign word_s   = {2'b00, addr_i[31:2]} % 32'(DEPTH);
  assign rdata_o  = memfile[word_s[AW-1:0]];
  assign unused_s = ^{addr_i[1:0], word_s[31:AW]};

  // Optional program load; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (load_we_i) memfile[load_addr_i] <= load_data_i;
  end
endmodule

// 32x32 register file: two combinational read ports, one write port, x0 hardwired to zero.
module riscv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] regs [0:31];

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs[raddr2_i];

  // Clear every register on reset; ignore writes that target x0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end
endmodule

// Word-addressed data RAM: combinational read, write on the rising edge.
module riscv_dmem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] word_s;
  logic        unused_s;

  // Low two address bits are ignored; the word index wraps at the depth.
  assign word_s   = {2'b00, addr_i[31:2]} % 32'(DEPTH);
  assign rdata_o  = mem[word_s[AW-1:0]];
  assign unused_s = ^{addr_i[1:0], word_s[31:AW]};

  // Clear the whole array on reset, otherwise commit store data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (we_i) begin
      mem[word_s[AW-1:0]] <= wdata_i;
    end
  end
endmodule

module riscv_single_cycle_core #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic rst
);
  localparam int         IAW       = $clog2(IMEM_DEPTH);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [31:0] pc, pc_d, instr, pc_plus4_s;
  logic [6:0]  opcode_s, funct7_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s;
  logic [31:0] rs1_val_s, rs2_val_s, rd_wdata_s, mem_addr_s, mem_rdata_s;
  logic        rd_we_s, mem_we_s, taken_s;

  riscv_imem #(.DEPTH(IMEM_DEPTH)) insmem (
    .clk(clk), .load_we_i(1'b0), .load_addr_i({IAW{1'b0}}), .load_data_i(32'd0),
    .addr_i(pc), .rdata_o(instr)
  );

  riscv_regfile rf (
    .clk(clk), .rst(rst), .we_i(rd_we_s), .waddr_i(rd_s), .wdata_i(rd_wdata_s),
    .raddr1_i(rs1_s), .raddr2_i(rs2_s), .rdata1_o(rs1_val_s), .rdata2_o(rs2_val_s)
  );

  riscv_dmem #(.DEPTH(DMEM_DEPTH)) dmem (
    .clk(clk), .rst(rst), .we_i(mem_we_s), .addr_i(mem_addr_s),
    .wdata_i(rs2_val_s), .rdata_o(mem_rdata_s)
  );

  assign opcode_s   = instr[6:0];
  assign rd_s       = instr[11:7];
  assign funct3_s   = instr[14:12];
  assign rs1_s      = instr[19:15];
  assign rs2_s      = instr[24:20];
  assign funct7_s   = instr[31:25];
  assign imm_i_s    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j_s    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u_s    = {instr[31:12], 12'd0};
  assign pc_plus4_s = pc + 32'd4;
  assign mem_addr_s = rs1_val_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);

  // Decode and execute; anything not recognised falls back to a NOP (pc+4, no writes).
  always_comb begin
    pc_d       = pc_plus4_s;
    rd_we_s    = 1'b0;
    rd_wdata_s = 32'd0;
    mem_we_s   = 1'b0;
    taken_s    = 1'b0;
    case (opcode_s)
      OP_R: begin
        rd_we_s = 1'b1;
        case ({funct7_s, funct3_s})
          10'b0000000_000: rd_wdata_s = rs1_val_s + rs2_val_s;
          10'b0100000_000: rd_wdata_s = rs1_val_s - rs2_val_s;
          10'b0000000_001: rd_wdata_s = rs1_val_s << rs2_val_s[4:0];
          10'b0000000_010: rd_wdata_s = {31'd0, $signed(rs1_val_s) < $signed(rs2_val_s)};
          10'b0000000_011: rd_wdata_s = {31'd0, rs1_val_s < rs2_val_s};
          10'b0000000_100: rd_wdata_s = rs1_val_s ^ rs2_val_s;
          10'b0000000_101: rd_wdata_s = rs1_val_s >> rs2_val_s[4:0];
          10'b0100000_101: rd_wdata_s = $signed(rs1_val_s) >>> rs2_val_s[4:0];
          10'b0000000_110: rd_wdata_s = rs1_val_s | rs2_val_s;
          10'b0000000_111: rd_wdata_s = rs1_val_s & rs2_val_s;
          default:         rd_we_s    = 1'b0;
        endcase
      end
      OP_IMM: begin
        rd_we_s = 1'b1;
        case (funct3_s)
          3'b000: rd_wdata_s = rs1_val_s + imm_i_s;
          3'b010: rd_wdata_s = {31'd0, $signed(rs1_val_s) < $signed(imm_i_s)};
          3'b011: rd_wdata_s = {31'd0, rs1_val_s < imm_i_s};
          3'b100: rd_wdata_s = rs1_val_s ^ imm_i_s;
          3'b110: rd_wdata_s = rs1_val_s | imm_i_s;
          3'b111: rd_wdata_s = rs1_val_s & imm_i_s;
          3'b001: begin
            if (funct7_s == 7'b0000000) rd_wdata_s = rs1_val_s << imm_i_s[4:0];
            else                        rd_we_s    = 1'b0;
          end
          3'b101: begin
            if (funct7_s == 7'b0000000)      rd_wdata_s = rs1_val_s >> imm_i_s[4:0];
            else if (funct7_s == 7'b0100000) rd_wdata_s = $signed(rs1_val_s) >>> imm_i_s[4:0];
            else                             rd_we_s    = 1'b0;
          end
          default: rd_we_s = 1'b0;
        endcase
      end
      OP_LOAD: begin
        if (funct3_s == 3'b010) begin
          rd_we_s    = 1'b1;
          rd_wdata_s = mem_rdata_s;
        end else begin
          rd_we_s    = 1'b0;
        end
      end
      OP_STORE: begin
        if (funct3_s == 3'b010) mem_we_s = 1'b1;
        else                    mem_we_s = 1'b0;
      end
      OP_BRANCH: begin
        case (funct3_s)
          3'b000:  taken_s = (rs1_val_s == rs2_val_s);
          3'b001:  taken_s = (rs1_val_s != rs2_val_s);
          3'b100:  taken_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
          3'b101:  taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
          3'b110:  taken_s = (rs1_val_s <  rs2_val_s);
          3'b111:  taken_s = (rs1_val_s >= rs2_val_s);
          default: taken_s = 1'b0;
        endcase
        if (taken_s) pc_d = pc + imm_b_s;
        else         pc_d = pc_plus4_s;
      end
      OP_JAL: begin
        rd_we_s    = 1'b1;
        rd_wdata_s = pc_plus4_s;
        pc_d       = pc + imm_j_s;
      end
      OP_JALR: begin
        if (funct3_s == 3'b000) begin
          rd_we_s    = 1'b1;
          rd_wdata_s = pc_plus4_s;
          pc_d       = (rs1_val_s + imm_i_s) & ~32'd1;
        end else begin
          rd_we_s    = 1'b0;
        end
      end
      OP_LUI: begin
        rd_we_s    = 1'b1;
        rd_wdata_s = imm_u_s;
      end
      OP_AUIPC: begin
        rd_we_s    = 1'b1;
        rd_wdata_s = pc + imm_u_s;
      end
      default: rd_we_s = 1'b0;
    endcase
  end

  // Program counter: cleared immediately by reset, otherwise advances every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'd0;
    else      pc <= pc_d;
  end
endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// Self-checking bench for riscv_single_cycle_core: directed programs with
// fixed expected values plus random programs checked against an ISA model.
module tb_riscv_single_cycle_core;
  localparam int IMEM = 256;
  localparam int DMEM = 256;

  logic clk, rst;
  int   errors, checks;

  logic [31:0] m_imem [IMEM];
  logic [31:0] m_dmem [DMEM];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  riscv_single_cycle_core #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM)) dut (.clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] j_t(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] u_t(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm[19:0], rd, op};
  endfunction

  // ---------------- reference ISA model ----------------
  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < DMEM; i++) m_dmem[i] = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, imm_u, res, nxt;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          wr, tk;
    ins   = m_imem[int'((m_pc >> 2) % IMEM)];
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
    a     = m_regs[ins[19:15]];
    b     = m_regs[ins[24:20]];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    imm_u = {ins[31:12], 12'd0};
    nxt = m_pc + 32'd4; wr = 1'b0; res = 32'd0; tk = 1'b0;
    case (op)
      7'h33: begin
        wr = 1'b1;
        if (f7 == 7'h00 && f3 == 3'd0)      res = a + b;
        else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
        else if (f7 == 7'h00 && f3 == 3'd1) res = a << b[4:0];
        else if (f7 == 7'h00 && f3 == 3'd2) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (f7 == 7'h00 && f3 == 3'd3) res = (a < b) ? 32'd1 : 32'd0;
        else if (f7 == 7'h00 && f3 == 3'd4) res = a ^ b;
        else if (f7 == 7'h00 && f3 == 3'd5) res = a >> b[4:0];
        else if (f7 == 7'h20 && f3 == 3'd5) res = $signed(a) >>> b[4:0];
        else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
        else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
        else wr = 1'b0;
      end
      7'h13: begin
        wr = 1'b1;
        if (f3 == 3'd0)                     res = a + imm_i;
        else if (f3 == 3'd2)                res = ($signed(a) < $signed(imm_i)) ? 32'd1 : 32'd0;
        else if (f3 == 3'd3)                res = (a < imm_i) ? 32'd1 : 32'd0;
        else if (f3 == 3'd4)                res = a ^ imm_i;
        else if (f3 == 3'd6)                res = a | imm_i;
        else if (f3 == 3'd7)                res = a & imm_i;
        else if (f3 == 3'd1 && f7 == 7'h00) res = a << imm_i[4:0];
        else if (f3 == 3'd5 && f7 == 7'h00) res = a >> imm_i[4:0];
        else if (f3 == 3'd5 && f7 == 7'h20) res = $signed(a) >>> imm_i[4:0];
        else wr = 1'b0;
      end
      7'h03: if (f3 == 3'd2) begin wr = 1'b1; res = m_dmem[int'(((a + imm_i) >> 2) % DMEM)]; end
      7'h23: if (f3 == 3'd2) m_dmem[int'(((a + imm_s) >> 2) % DMEM)] = b;
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = !($signed(a) < $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = !(a < b);
          default: tk = 1'b0;
        endcase
        if (tk) nxt = m_pc + imm_b;
      end
      7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + imm_j; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + imm_i) & 32'hFFFF_FFFE; end
      7'h37: begin wr = 1'b1; res = imm_u; end
      7'h17: begin wr = 1'b1; res = m_pc + imm_u; end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 5'd0) m_regs[rd] = res;
    m_pc = nxt;
  endtask

  // Random instruction drawn from every supported class plus some illegal variants.
  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    int          k, off, p;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = $urandom;
    off = int'($urandom_range(0, 16)) - 8;
    if (off == 0) off = 1;
    p   = int'($urandom_range(0, 3));
    k   = int'($urandom_range(0, 11));
    case (k)
      0, 10: begin
        f7 = (p == 2) ? 7'h20 : ((p == 3) ? 7'h01 : 7'h00);
        return r_t(f7, rs2, rs1, f3, rd);
      end
      1, 11: begin
        if (f3 == 3'd1 && p != 3) imm[11:5] = 7'h00;
        if (f3 == 3'd5 && p != 3) imm[11:5] = (p == 2) ? 7'h20 : 7'h00;
        return i_t(imm, rs1, f3, rd, 7'h13);
      end
      2: return u_t(imm, rd, 7'h37);
      3: return u_t(imm, rd, 7'h17);
      4: return s_t(imm, rs2, rs1, (p == 3) ? f3 : 3'd2);
      5: return i_t(imm, rs1, (p == 3) ? f3 : 3'd2, rd, 7'h03);
      6: return b_t(32'(off * 4), rs2, rs1, f3);
      7: return j_t(32'(off * 4), rd);
      8: return i_t(imm, rs1, (p == 3) ? f3 : 3'd0, rd, 7'h67);
      default: return $urandom;
    endcase
  endfunction

  // Hold reset, load program into DUT and model, release on a falling edge.
  task automatic load_prog(input logic [31:0] prog [$]);
    logic [31:0] v;
    rst = 1'b0;
    #1;
    for (int i = 0; i < IMEM; i++) begin
      v = (i < prog.size()) ? prog[i] : 32'd0;
      dut.insmem.memfile[i] = v;
      m_imem[i] = v;
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    if (dut.pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'd0); end
    checks++;
    for (int i = 0; i < 32; i++) begin
      if (dut.rf.regs[i] !== 32'd0) begin errors++; $display("FAIL reset_x%0d: got %h expected 0", i, dut.rf.regs[i]); end
      checks++;
    end
    for (int i = 0; i < DMEM; i++) begin
      if (dut.dmem.mem[i] !== 32'd0) begin errors++; $display("FAIL reset_dmem%0d: got %h expected 0", i, dut.dmem.mem[i]); end
      checks++;
    end
  endtask

  task automatic test_alu();
    logic [31:0] p [$];
    p = {i_t(32'd5, 5'd0, 3'd0, 5'd1, 7'h13), i_t(-32'sd3, 5'd0, 3'd0, 5'd2, 7'h13),
         r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), r_t(7'h20, 5'd2, 5'd1, 3'd0, 5'd4),
         i_t(32'd3, 5'd1, 3'd1, 5'd5, 7'h13), i_t(32'h401, 5'd2, 3'd5, 5'd6, 7'h13),
         i_t(32'd28, 5'd2, 3'd5, 5'd7, 7'h13), r_t(7'h00, 5'd1, 5'd2, 3'd2, 5'd8),
         r_t(7'h00, 5'd1, 5'd2, 3'd3, 5'd9), i_t(32'h40, 5'd0, 3'd0, 5'd10, 7'h13),
         s_t(32'd4, 5'd1, 5'd10, 3'd2), i_t(32'd4, 5'd10, 3'd2, 5'd11, 7'h03),
         i_t(32'd7, 5'd0, 3'd0, 5'd0, 7'h13)};
    load_prog(p);
    repeat (4) @(negedge clk);
    if (dut.rf.regs[3] !== 32'd2) begin errors++; $display("FAIL add_x3: got %h expected %h", dut.rf.regs[3], 32'd2); end
    checks++;
    if (dut.rf.regs[4] !== 32'd8) begin errors++; $display("FAIL sub_x4: got %h expected %h", dut.rf.regs[4], 32'd8); end
    checks++;
    if (dut.pc !== 32'd16) begin errors++; $display("FAIL alu_pc: got %h expected %h", dut.pc, 32'd16); end
    checks++;
  endtask

  task automatic test_logic();
    repeat (5) @(negedge clk);
    if (dut.rf.regs[5] !== 32'd40) begin errors++; $display("FAIL slli_x5: got %h expected %h", dut.rf.regs[5], 32'd40); end
    checks++;
    if (dut.rf.regs[6] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL srai_x6: got %h expected %h", dut.rf.regs[6], 32'hFFFF_FFFE); end
    checks++;
    if (dut.rf.regs[7] !== 32'h0000_000F) begin errors++; $display("FAIL srli_x7: got %h expected %h", dut.rf.regs[7], 32'h0000_000F); end
    checks++;
    if (dut.rf.regs[8] !== 32'd1) begin errors++; $display("FAIL slt_x8: got %h expected %h", dut.rf.regs[8], 32'd1); end
    checks++;
    if (dut.rf.regs[9] !== 32'd0) begin errors++; $display("FAIL sltu_x9: got %h expected %h", dut.rf.regs[9], 32'd0); end
    checks++;
  endtask

  task automatic test_memory();
    repeat (4) @(negedge clk);
    if (dut.dmem.mem[17] !== 32'd5) begin errors++; $display("FAIL sw_mem17: got %h expected %h", dut.dmem.mem[17], 32'd5); end
    checks++;
    if (dut.rf.regs[11] !== 32'd5) begin errors++; $display("FAIL lw_x11: got %h expected %h", dut.rf.regs[11], 32'd5); end
    checks++;
    if (dut.rf.regs[0] !== 32'd0) begin errors++; $display("FAIL x0_write: got %h expected %h", dut.rf.regs[0], 32'd0); end
    checks++;
    if (dut.pc !== 32'd52) begin errors++; $display("FAIL mem_pc: got %h expected %h", dut.pc, 32'd52); end
    checks++;
  endtask

  task automatic test_control();
    logic [31:0] p [$];
    p = {i_t(32'd5, 5'd0, 3'd0, 5'd1, 7'h13), b_t(32'd8, 5'd1, 5'd1, 3'd0),
         i_t(32'd1, 5'd0, 3'd0, 5'd20, 7'h13), b_t(32'd8, 5'd1, 5'd1, 3'd1),
         i_t(32'd2, 5'd0, 3'd0, 5'd21, 7'h13), j_t(32'd12, 5'd12),
         u_t(32'h12345, 5'd13, 7'h37), j_t(32'd16, 5'd0),
         u_t(32'd1, 5'd14, 7'h17), i_t(32'd3, 5'd0, 3'd0, 5'd22, 7'h13),
         i_t(32'd0, 5'd12, 3'd0, 5'd0, 7'h67), i_t(32'd4, 5'd0, 3'd0, 5'd23, 7'h13)};
    load_prog(p);
    repeat (2) @(negedge clk);
    if (dut.pc !== 32'd12) begin errors++; $display("FAIL beq_taken_pc: got %h expected %h", dut.pc, 32'd12); end
    checks++;
    @(negedge clk);
    if (dut.pc !== 32'd16) begin errors++; $display("FAIL bne_fall_pc: got %h expected %h", dut.pc, 32'd16); end
    checks++;
    repeat (2) @(negedge clk);
    if (dut.pc !== 32'd32) begin errors++; $display("FAIL jal_pc: got %h expected %h", dut.pc, 32'd32); end
    checks++;
    if (dut.rf.regs[12] !== 32'd24) begin errors++; $display("FAIL jal_link: got %h expected %h", dut.rf.regs[12], 32'd24); end
    checks++;
    @(negedge clk);
    if (dut.rf.regs[14] !== 32'h1020) begin errors++; $display("FAIL auipc_x14: got %h expected %h", dut.rf.regs[14], 32'h1020); end
    checks++;
    repeat (2) @(negedge clk);
    if (dut.pc !== 32'd24) begin errors++; $display("FAIL jalr_pc: got %h expected %h", dut.pc, 32'd24); end
    checks++;
    @(negedge clk);
    if (dut.rf.regs[13] !== 32'h1234_5000) begin errors++; $display("FAIL lui_x13: got %h expected %h", dut.rf.regs[13], 32'h1234_5000); end
    checks++;
    @(negedge clk);
    if (dut.pc !== 32'd44) begin errors++; $display("FAIL jal_x0_pc: got %h expected %h", dut.pc, 32'd44); end
    checks++;
    @(negedge clk);
    if (dut.pc !== 32'd48) begin errors++; $display("FAIL ctrl_end_pc: got %h expected %h", dut.pc, 32'd48); end
    checks++;
  endtask

  // Word 12 of the control program is 0x00000000: only pc may move.
  task automatic test_nop();
    logic [31:0] exp_r [32];
    for (int i = 0; i < 32; i++) exp_r[i] = 32'd0;
    exp_r[1] = 32'd5; exp_r[12] = 32'd24; exp_r[13] = 32'h1234_5000; exp_r[14] = 32'h1020;
    exp_r[21] = 32'd2; exp_r[22] = 32'd3; exp_r[23] = 32'd4;
    @(negedge clk);
    if (dut.pc !== 32'd52) begin errors++; $display("FAIL nop_pc: got %h expected %h", dut.pc, 32'd52); end
    checks++;
    for (int i = 0; i < 32; i++) begin
      if (dut.rf.regs[i] !== exp_r[i]) begin errors++; $display("FAIL nop_x%0d: got %h expected %h", i, dut.rf.regs[i], exp_r[i]); end
      checks++;
    end
    for (int i = 0; i < DMEM; i++) begin
      if (dut.dmem.mem[i] !== 32'd0) begin errors++; $display("FAIL nop_dmem%0d: got %h expected 0", i, dut.dmem.mem[i]); end
      checks++;
    end
  endtask

  task automatic run_vs_model(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      model_step();
      if (dut.pc !== m_pc) begin errors++; $display("FAIL %s_pc cyc%0d: got %h expected %h", tag, c, dut.pc, m_pc); end
      checks++;
      for (int i = 0; i < 32; i++) begin
        if (dut.rf.regs[i] !== m_regs[i]) begin
          errors++; $display("FAIL %s_x%0d cyc%0d: got %h expected %h", tag, i, c, dut.rf.regs[i], m_regs[i]);
        end
        checks++;
      end
    end
    for (int i = 0; i < DMEM; i++) begin
      if (dut.dmem.mem[i] !== m_dmem[i]) begin errors++; $display("FAIL %s_dmem%0d: got %h expected %h", tag, i, dut.dmem.mem[i], m_dmem[i]); end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [31:0] p [$];
    for (int i = 0; i < IMEM; i++) p.push_back(gen_instr());
    load_prog(p);
    run_vs_model("rand", 300);
  endtask

  // Async reset between clock edges must clear state at once; then the program replays.
  task automatic test_reset_mid();
    #2 rst = 1'b0;
    #1;
    if (dut.pc !== 32'd0) begin errors++; $display("FAIL midrst_pc: got %h expected %h", dut.pc, 32'd0); end
    checks++;
    for (int i = 0; i < 32; i++) begin
      if (dut.rf.regs[i] !== 32'd0) begin errors++; $display("FAIL midrst_x%0d: got %h expected 0", i, dut.rf.regs[i]); end
      checks++;
    end
    for (int i = 0; i < DMEM; i++) begin
      if (dut.dmem.mem[i] !== 32'd0) begin errors++; $display("FAIL midrst_dmem%0d: got %h expected 0", i, dut.dmem.mem[i]); end
      checks++;
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_vs_model("replay", 300);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    #2;
    test_reset();
    test_alu();
    test_logic();
    test_memory();
    test_control();
    test_nop();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
